// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell is reused across WIDTH
// cycles, LSB first. Operands arrive and results leave on valid/ready channels.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds with its payload stable until that edge.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             sub_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic [1:0]       state_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_cout;
    logic             accept, last;
    logic [WIDTH:0]   res_shift;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign accept    = (state == IDLE) && req_valid_i;
    assign last      = (state == RUN) && (cnt == LAST);
    // Sum bit enters at the MSB; the extra bit keeps the slice legal for WIDTH=1.
    assign res_shift = {fa_s, res_sr};
    assign state_o   = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (res_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_ready_o <= 1'b1;
            res_valid_o <= 1'b0;
        end else begin
            req_ready_o <= (state_next == IDLE);
            res_valid_o <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_o  <= '0;
            cout_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else if (accept) begin
            a_sr  <= op_a_i;
            b_sr  <= sub_i ? ~op_b_i : op_b_i;
            carry <= sub_i;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_shift[WIDTH:1];
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                // Published outputs change only here, so they hold through DONE and IDLE.
                sum_o  <= res_shift[WIDTH:1];
                cout_o <= fa_cout;
                ovf_o  <= carry ^ fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed vector table, corner sequences and
// randomized operations against an arithmetic reference, on WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
    logic clk, rst;

    logic       req_valid, req_ready, sub, res_valid, res_ready, cout, ovf;
    logic [7:0] op_a, op_b, sum;
    logic [1:0] state8;

    logic req_valid1, req_ready1, sub1, res_valid1, res_ready1, cout1, ovf1;
    logic [0:0] op_a1, op_b1, sum1;
    logic [1:0] state1;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[4];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .op_a_i(op_a), .op_b_i(op_b), .sub_i(sub), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .state_o(state8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .op_a_i(op_a1), .op_b_i(op_b1), .sub_i(sub1), .res_valid_o(res_valid1),
        .res_ready_i(res_ready1), .sum_o(sum1), .cout_o(cout1), .ovf_o(ovf1), .state_o(state1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on plain integers, returns {ovf, cout, sum}.
    function automatic logic [9:0] model(input int w, input int a, input int b, input int s);
        int full, t, sa, sb, r;
        logic [9:0] out;
        full = 1 << w;
        t  = s ? (a + (full - 1 - b) + 1) : (a + b);
        sa = (a >= full / 2) ? a - full : a;
        sb = (b >= full / 2) ? b - full : b;
        r  = s ? sa - sb : sa + sb;
        out = '0;
        out[7:0] = 8'(t % full);
        out[8]   = ((t / full) % 2) != 0;
        out[9]   = (r < -(full / 2)) || (r >= full / 2);
        return out;
    endfunction

    task automatic wait_ready8();
        int cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // One WIDTH=8 operation; iso scrambles inputs and holds req_valid during RUN/DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int hold, input bit iso);
        int cyc;
        logic [9:0] exp;
        logic [7:0] held;
        wait_ready8();
        op_a = a; op_b = b; sub = s; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = iso;
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            op_a = 8'($urandom); op_b = 8'($urandom); sub = 1'($urandom);
            if (iso) check("iso_ready_run", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 8);
        exp = exp_q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, exp[7:0]});
        check("cout", {31'd0, cout}, {31'd0, exp[8]});
        check("ovf", {31'd0, ovf}, {31'd0, exp[9]});
        held = sum;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_sum", {24'd0, sum}, {24'd0, held});
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("post_hs_valid", {31'd0, res_valid}, 32'd0);
        check("post_hs_ready", {31'd0, req_ready}, 32'd1);
        check("post_hs_sum", {24'd0, sum}, {24'd0, held});
        req_valid = 1'b0;
    endtask

    task automatic op1(input logic a, input logic b, input logic s,
                       input logic [9:0] exp);
        int cyc = 0;
        while (!req_ready1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w1_ready", {31'd0, req_ready1}, 32'd1);
        op_a1 = a; op_b1 = b; sub1 = s; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        cyc = 0;
        while (!res_valid1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w1_latency", cyc, 1);
        check("w1_sum", {31'd0, sum1}, {31'd0, exp[0]});
        check("w1_cout", {31'd0, cout1}, {31'd0, exp[8]});
        check("w1_ovf", {31'd0, ovf1}, {31'd0, exp[9]});
        res_ready1 = 1'b1;
        @(posedge clk); #1;
        res_ready1 = 1'b0;
    endtask

    initial begin
        int seen;
        logic [7:0] ra, rb;
        logic rs;

        vecs[0] = '{a: 8'd100, b: 8'd55, sub: 1'b0, sum: 8'd155, cout: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 8'd255, b: 8'd1,  sub: 1'b0, sum: 8'd0,   cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 8'd7,  sub: 1'b1, sum: 8'd254, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h80,  b: 8'h01, sub: 1'b1, sum: 8'h7F,  cout: 1'b1, ovf: 1'b1};

        rst = 1'b1;
        req_valid = 0; res_ready = 0; op_a = 0; op_b = 0; sub = 0;
        req_valid1 = 0; res_ready1 = 0; op_a1 = 0; op_b1 = 0; sub1 = 0;
        #3;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_outs", {22'd0, ovf, cout, sum}, 32'd0);
        check("rst_w1", {28'd0, req_ready1, res_valid1, cout1, ovf1}, 32'h8);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({vecs[i].ovf, vecs[i].cout, vecs[i].sum});
            op8(vecs[i].a, vecs[i].b, vecs[i].sub, 0, 1'b0);
        end

        // Input isolation and backpressure on 10+20.
        exp_q.push_back(10'd30);
        op8(8'd10, 8'd20, 1'b0, 5, 1'b1);

        // Asynchronous reset in the third RUN cycle.
        wait_ready8();
        op_a = 8'd9; op_b = 8'd9; sub = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        check("arst_valid", {31'd0, res_valid}, 32'd0);
        check("arst_outs", {22'd0, ovf, cout, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        check("arst_no_pulse", seen, 0);
        exp_q.push_back(10'd7);
        op8(8'd3, 8'd4, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            exp_q.push_back(model(8, int'(ra), int'(rb), int'(rs)));
            op8(ra, rb, rs, $urandom_range(0, 2), 1'b0);
        end

        op1(1'b1, 1'b1, 1'b0, {1'b1, 1'b1, 8'd0});
        op1(1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 8'd1});
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1)); rs = 1'($urandom);
            op1(ra[0], rb[0], rs, model(1, int'(ra), int'(rb), int'(rs)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
